cam_fifo_write: RTL and testbench

CAM_FIFO_WRITE -- requirements
Module: cam_fifo_write

---
 rtl/cam_fifo_write.sv | 185 ++++++++++++++++++
 tb/tb_cam_fifo_write.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_fifo_write.sv
// ============================================================================
// Module      : cam_fifo_write
// Description : Captures one camera frame into a downstream FIFO after
//               discarding SKIP_FRAMES frames. Optional macro
//               CAM_BYTE_COUNT_EN enables the saturating byte counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_fifo_write #(
    parameter int SKIP_FRAMES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture_start,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        fifo_is_full,
    output logic        fifo_write_en,
    output logic [7:0]  dataout,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow,
    output logic [19:0] byte_count
);

    localparam int c_SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [c_SKIP_W-1:0] c_SKIP_INIT = c_SKIP_W'(SKIP_FRAMES);
    localparam logic [c_SKIP_W-1:0] c_SKIP_ONE  = c_SKIP_W'(1);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_WAIT_FRAME = 3'd1;
    localparam logic [2:0] c_SKIP       = 3'd2;
    localparam logic [2:0] c_CAPTURE    = 3'd3;
    localparam logic [2:0] c_DONE       = 3'd4;

    // Bit 0 is the first synchroniser stage (s1), bit 1 is s2, bit 2 is s3.
    logic [2:0]          r_pclk_sync_q,  w_pclk_sync_d;
    logic [2:0]          r_vsync_sync_q, w_vsync_sync_d;
    logic [1:0]          r_href_sync_q,  w_href_sync_d;
    logic [7:0]          r_data_s1_q,    w_data_s1_d;
    logic [7:0]          r_data_s2_q,    w_data_s2_d;

    logic [2:0]          r_state_q,         w_state_d;
    logic [c_SKIP_W-1:0] r_skip_q,          w_skip_d;
    logic                r_fifo_write_en_q, w_fifo_write_en_d;
    logic [7:0]          r_dataout_q,       w_dataout_d;
    logic                r_busy_q,          w_busy_d;
    logic                r_frame_done_q,    w_frame_done_d;
    logic                r_overflow_q,      w_overflow_d;

    logic                w_pix_edge;
    logic                w_vsync_rise;
    logic                w_vsync_fall;

    always_comb begin
        w_pclk_sync_d  = {r_pclk_sync_q[1:0], cam_pclk};
        w_vsync_sync_d = {r_vsync_sync_q[1:0], cam_vsync};
        w_href_sync_d  = {r_href_sync_q[0], cam_href};
        w_data_s1_d    = cam_data;
        w_data_s2_d    = r_data_s1_q;
    end

    assign w_pix_edge   =  r_pclk_sync_q[1]  & ~r_pclk_sync_q[2];
    assign w_vsync_rise =  r_vsync_sync_q[1] & ~r_vsync_sync_q[2];
    assign w_vsync_fall = ~r_vsync_sync_q[1] &  r_vsync_sync_q[2];

    always_comb begin
        w_state_d         = r_state_q;
        w_skip_d          = r_skip_q;
        w_fifo_write_en_d = 1'b0;
        w_dataout_d       = r_dataout_q;
        w_frame_done_d    = 1'b0;
        w_overflow_d      = r_overflow_q;

        case (r_state_q)
            c_IDLE: begin
                if (capture_start) begin
                    w_state_d    = c_WAIT_FRAME;
                    w_overflow_d = 1'b0;
                    w_skip_d     = c_SKIP_INIT;
                end
            end
            c_WAIT_FRAME: begin
                if (w_vsync_fall) begin
                    w_state_d = (r_skip_q != '0) ? c_SKIP : c_CAPTURE;
                end
            end
            c_SKIP: begin
                if (w_vsync_rise) begin
                    w_skip_d  = r_skip_q - c_SKIP_ONE;
                    w_state_d = c_WAIT_FRAME;
                end
            end
            c_CAPTURE: begin
                // End of frame wins over a coincident pixel edge.
                if (w_vsync_rise) begin
                    w_state_d      = c_DONE;
                    w_frame_done_d = 1'b1;
                end else if (w_pix_edge && r_href_sync_q[1]) begin
                    if (!fifo_is_full) begin
                        w_fifo_write_en_d = 1'b1;
                        w_dataout_d       = r_data_s2_q;
                    end else begin
                        w_overflow_d = 1'b1;
                    end
                end
            end
            c_DONE: begin
                w_state_d = c_IDLE;
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != c_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pclk_sync_q     <= '0;
            r_vsync_sync_q    <= '0;
            r_href_sync_q     <= '0;
            r_data_s1_q       <= '0;
            r_data_s2_q       <= '0;
            r_state_q         <= c_IDLE;
            r_skip_q          <= '0;
            r_fifo_write_en_q <= 1'b0;
            r_dataout_q       <= '0;
            r_busy_q          <= 1'b0;
            r_frame_done_q    <= 1'b0;
            r_overflow_q      <= 1'b0;
        end else begin
            r_pclk_sync_q     <= w_pclk_sync_d;
            r_vsync_sync_q    <= w_vsync_sync_d;
            r_href_sync_q     <= w_href_sync_d;
            r_data_s1_q       <= w_data_s1_d;
            r_data_s2_q       <= w_data_s2_d;
            r_state_q         <= w_state_d;
            r_skip_q          <= w_skip_d;
            r_fifo_write_en_q <= w_fifo_write_en_d;
            r_dataout_q       <= w_dataout_d;
            r_busy_q          <= w_busy_d;
            r_frame_done_q    <= w_frame_done_d;
            r_overflow_q      <= w_overflow_d;
        end
    end

    assign fifo_write_en = r_fifo_write_en_q;
    assign dataout       = r_dataout_q;
    assign busy          = r_busy_q;
    assign frame_done    = r_frame_done_q;
    assign overflow      = r_overflow_q;

`ifdef CAM_BYTE_COUNT_EN
    logic [19:0] r_byte_count_q, w_byte_count_d;

    always_comb begin
        w_byte_count_d = r_byte_count_q;
        if ((r_state_q == c_IDLE) && capture_start) begin
            w_byte_count_d = '0;
        end else if (r_fifo_write_en_q && (r_byte_count_q != 20'hFFFFF)) begin
            w_byte_count_d = r_byte_count_q + 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byte_count_q <= '0;
        end else begin
            r_byte_count_q <= w_byte_count_d;
        end
    end

    assign byte_count = r_byte_count_q;
`else
    assign byte_count = 20'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cam_fifo_write.sv
// ============================================================================
// Module      : tb_cam_fifo_write
// Description : Self-checking bench for cam_fifo_write (SKIP_FRAMES 0 and 2)
//               against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_fifo_write;

    typedef logic [7:0] u8_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs0 = 1'b0, cs1 = 1'b0;
    logic        pclk = 1'b0, vsync = 1'b1, href = 1'b0, full = 1'b0;
    logic [7:0]  data = 8'h00;

    logic        wen0, busy0, done0, ovf0;
    logic [7:0]  dout0;
    logic [19:0] cnt0;
    logic        wen1, busy1, done1, ovf1;
    logic [7:0]  dout1;
    logic [19:0] cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    u8_t q0[$], q1[$];
    int  nd0 = 0, nd1 = 0;
    u8_t fdat[$];
    bit  ffull[$];

    always #5 clk = ~clk;

    cam_fifo_write #(.SKIP_FRAMES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .capture_start(cs0),
        .cam_pclk(pclk), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
        .fifo_is_full(full), .fifo_write_en(wen0), .dataout(dout0),
        .busy(busy0), .frame_done(done0), .overflow(ovf0), .byte_count(cnt0)
    );

    cam_fifo_write #(.SKIP_FRAMES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .capture_start(cs1),
        .cam_pclk(pclk), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
        .fifo_is_full(full), .fifo_write_en(wen1), .dataout(dout1),
        .busy(busy1), .frame_done(done1), .overflow(ovf1), .byte_count(cnt1)
    );

    always @(negedge clk) begin
        if (wen0) q0.push_back(dout0);
        if (wen1) q1.push_back(dout1);
        if (done0) nd0++;
        if (done1) nd1++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int exp_count(input int n);
`ifdef CAM_BYTE_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic build_frame(input int n, input int first, input bit rnd_full);
        fdat.delete();
        ffull.delete();
        for (int k = 0; k < n; k++) begin
            fdat.push_back((first >= 0) ? u8_t'(first + k) : u8_t'($urandom_range(0, 255)));
            ffull.push_back(rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0);
        end
    endtask

    task automatic pix(input u8_t d, input logic h, input logic f);
        data = d;
        href = h;
        full = f;
        pclk = 1'b0;
        repeat (4) @(negedge clk);
        pclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input int bpl, input int abort_idx, input int dup_idx);
        vsync = 1'b0;
        repeat (3) pix(8'h00, 1'b0, 1'b0);
        for (int k = 0; k < fdat.size(); k++) begin
            if (k == abort_idx) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check_eq("rst_wen",   32'(wen0),   32'd0);
                check_eq("rst_dout",  32'(dout0),  32'd0);
                check_eq("rst_busy",  32'(busy0),  32'd0);
                check_eq("rst_done",  32'(done0),  32'd0);
                check_eq("rst_ovf",   32'(ovf0),   32'd0);
                check_eq("rst_cnt",   32'(cnt0),   32'd0);
            end
            if (k == dup_idx) begin
                cs0 = 1'b1;
                @(negedge clk);
                cs0 = 1'b0;
            end
            pix(fdat[k], 1'b1, ffull[k]);
            if ((k + 1) % bpl == 0) repeat (2) pix(8'h00, 1'b0, 1'b0);
        end
        vsync = 1'b1;
        repeat (3) pix(8'h00, 1'b0, 1'b0);
    endtask

    task automatic cmp_q(input string tag, input u8_t got[$], input u8_t exp[$]);
        check_eq({tag, "_nwr"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check_eq($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    endtask

    // Capture one frame on the SKIP_FRAMES=0 instance and score it.
    task automatic run0(input string tag, input int bpl, input int abort_idx, input int dup_idx);
        u8_t exp[$];
        bit  any_full = 1'b0;
        int  upto = (abort_idx >= 0) ? abort_idx : fdat.size();
        q0.delete();
        nd0 = 0;
        cs0 = 1'b1;
        @(negedge clk);
        cs0 = 1'b0;
        repeat (4) @(negedge clk);
        check_eq({tag, "_busy_start"}, 32'(busy0), 32'd1);
        check_eq({tag, "_ovf_clear"},  32'(ovf0),  32'd0);
        send_frame(bpl, abort_idx, dup_idx);
        for (int k = 0; k < upto; k++) begin
            if (ffull[k]) any_full = 1'b1;
            else exp.push_back(fdat[k]);
        end
        if (abort_idx >= 0) any_full = 1'b0;
        cmp_q(tag, q0, exp);
        check_eq({tag, "_done"}, 32'(nd0),   (abort_idx >= 0) ? 32'd0 : 32'd1);
        check_eq({tag, "_ovf"},  32'(ovf0),  32'(any_full));
        check_eq({tag, "_cnt"},  32'(cnt0),  (abort_idx >= 0) ? 32'd0 : 32'(exp_count(exp.size())));
        check_eq({tag, "_busy"}, 32'(busy0), 32'd0);
        if (abort_idx < 0 && exp.size() > 0)
            check_eq({tag, "_hold"}, 32'(dout0), 32'(exp[exp.size()-1]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        u8_t exp1[$];
        repeat (3) @(negedge clk);
        check_eq("reset_wen",  32'(wen0),  32'd0);
        check_eq("reset_dout", 32'(dout0), 32'd0);
        check_eq("reset_busy", 32'(busy0), 32'd0);
        check_eq("reset_done", 32'(done0), 32'd0);
        check_eq("reset_ovf",  32'(ovf0),  32'd0);
        check_eq("reset_cnt",  32'(cnt0),  32'd0);
        check_eq("reset_busy1", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        build_frame(8, 1, 1'b0);
        run0("basic", 4, -1, -1);

        build_frame(8, 1, 1'b0);
        ffull[2] = 1'b1;
        run0("full3", 4, -1, -1);
        repeat (10) @(negedge clk);
        check_eq("ovf_sticky", 32'(ovf0), 32'd1);

        build_frame(8, 'h40, 1'b0);
        run0("dup", 4, -1, 5);

        build_frame(8, 'h10, 1'b0);
        run0("abort", 4, 3, -1);

        build_frame(8, 'h20, 1'b0);
        run0("after_rst", 4, -1, -1);

        for (int r = 0; r < 6; r++) begin
            int bpl = $urandom_range(2, 5);
            build_frame(bpl * $urandom_range(1, 3), -1, 1'b1);
            run0($sformatf("rnd%0d", r), bpl, -1, -1);
        end

        // SKIP_FRAMES=2 instance: only the third frame is written.
        q0.delete();
        q1.delete();
        nd1 = 0;
        cs1 = 1'b1;
        @(negedge clk);
        cs1 = 1'b0;
        repeat (4) @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            build_frame(8, 'hA0 + 16 * f, 1'b0);
            send_frame(4, -1, -1);
            check_eq($sformatf("skip_done_f%0d", f), 32'(nd1), (f == 2) ? 32'd1 : 32'd0);
            if (f < 2) check_eq($sformatf("skip_nwr_f%0d", f), 32'(q1.size()), 32'd0);
        end
        for (int k = 0; k < fdat.size(); k++) exp1.push_back(fdat[k]);
        cmp_q("skip", q1, exp1);
        check_eq("skip_cnt",   32'(cnt1), 32'(exp_count(8)));
        check_eq("skip_idle0", 32'(q0.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
